// File: rtl/param_shift_register_file.sv
// Register bank with `depth` entries of `width` bits. Supports indexed writes, a shift-in window,
// synchronous clear, two combinational read ports, per-entry valid bits and a flat parallel bus.
module param_shift_register_file #(
    parameter int                unsigned width       = 32,
    parameter int                unsigned depth       = 5,
    parameter int                unsigned addr_width  = 3,
    parameter logic [width-1:0]           reset_value = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [addr_width-1:0]    write_index,
    input  logic [width-1:0]         write_data,
    input  logic                     shift_enable,
    input  logic [width-1:0]         shift_data,
    input  logic                     clear,
    input  logic [addr_width-1:0]    read_index0,
    output logic [width-1:0]         read_data0,
    input  logic [addr_width-1:0]    read_index1,
    output logic [width-1:0]         read_data1,
    output logic [width*depth-1:0]   all_data,
    output logic [depth-1:0]         valid_mask,
    output logic                     full
);

    logic [width-1:0] entries [depth];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int unsigned i = 0; i < depth; i++) begin
                entries[i] <= reset_value;
            end
            valid_mask <= '0;
        end else if (shift_enable) begin
            // A shift drops any concurrent indexed write entirely.
            for (int unsigned i = 0; i < depth - 1; i++) begin
                entries[i] <= entries[i+1];
            end
            entries[depth-1] <= shift_data;
            valid_mask       <= {1'b1, valid_mask[depth-1:1]};
        end else if (write_enable) begin
            for (int unsigned i = 0; i < depth; i++) begin
                if (write_index == addr_width'(i)) begin
                    entries[i]    <= write_data;
                    valid_mask[i] <= 1'b1;
                end
            end
        end
    end

    // Out-of-range indices match no entry, so both reads fall back to zero.
    always_comb begin
        read_data0 = '0;
        read_data1 = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            if (read_index0 == addr_width'(i)) begin
                read_data0 = entries[i];
            end
            if (read_index1 == addr_width'(i)) begin
                read_data1 = entries[i];
            end
        end
    end

    always_comb begin
        all_data = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            all_data[i*width +: width] = entries[i];
        end
    end

    assign full = &valid_mask;

endmodule

// File: tb/tb_param_shift_register_file.sv
// Directed bench for param_shift_register_file: a queue-based reference model checked every cycle,
// plus literal expectations pinning key states.
module tb_param_shift_register_file;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_enable = 1'b0;
    logic [2:0]    write_index = '0;
    logic [31:0]   write_data = '0;
    logic          shift_enable = 1'b0;
    logic [31:0]   shift_data = '0;
    logic          clear = 1'b0;
    logic [2:0]    read_index0 = '0;
    logic [31:0]   read_data0;
    logic [2:0]    read_index1 = '0;
    logic [31:0]   read_data1;
    logic [159:0]  all_data;
    logic [4:0]    valid_mask;
    logic          full;

    int checks = 0;
    int failures = 0;

    param_shift_register_file #(
        .width(32),
        .depth(5),
        .addr_width(3),
        .reset_value(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write_enable(write_enable),
        .write_index(write_index),
        .write_data(write_data),
        .shift_enable(shift_enable),
        .shift_data(shift_data),
        .clear(clear),
        .read_index0(read_index0),
        .read_data0(read_data0),
        .read_index1(read_index1),
        .read_data1(read_data1),
        .all_data(all_data),
        .valid_mask(valid_mask),
        .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the window is a queue; shifting pops the oldest entry and appends the new one.
    logic [31:0] mq[$];
    bit          mv[$];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset || clear) begin
            mq = {};
            mv = {};
            repeat (5) begin
                mq.push_back(RV);
                mv.push_back(1'b0);
            end
            model_ok = 1'b1;
        end else if (model_ok && shift_enable) begin
            void'(mq.pop_front());
            mq.push_back(shift_data);
            void'(mv.pop_front());
            mv.push_back(1'b1);
        end else if (model_ok && write_enable && write_index < 3'd5) begin
            mq[write_index] = write_data;
            mv[write_index] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] idx);
        return (idx < 3'd5) ? mq[idx] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            logic [159:0] ea;
            logic [4:0]   em;
            for (int i = 0; i < 5; i++) begin
                ea[i*32 +: 32] = mq[i];
                em[i]          = mv[i];
            end
            chk("model_all_data", all_data, ea);
            chk("model_valid_mask", 160'(valid_mask), 160'(em));
            chk("model_full", 160'(full), 160'(&em));
            chk("model_read_data0", 160'(read_data0), 160'(exp_rd(read_index0)));
            chk("model_read_data1", 160'(read_data1), 160'(exp_rd(read_index1)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        clear        = 1'b0;
        shift_enable = 1'b0;
        write_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step();
        chk("reset_all_data", all_data, {5{RV}});
        chk("reset_valid_mask", 160'(valid_mask), 160'(5'b00000));
        chk("reset_full", 160'(full), 160'(1'b0));

        write_enable = 1'b1; write_index = 3'd2; write_data = 32'h5555_5555;
        step();
        chk("write2_valid_mask", 160'(valid_mask), 160'(5'b00100));
        clear = 1'b1;
        step();
        chk("clear_all_data", all_data, {5{RV}});
        chk("clear_valid_mask", 160'(valid_mask), 160'(5'b00000));

        write_enable = 1'b1; write_index = 3'd0; write_data = 32'h1111_1111;
        step();
        write_enable = 1'b1; write_index = 3'd4; write_data = 32'h4444_4444;
        step();
        read_index0 = 3'd0; read_index1 = 3'd4;
        #1;
        chk("wr_read0_idx0", 160'(read_data0), 160'(32'h1111_1111));
        chk("wr_read1_idx4", 160'(read_data1), 160'(32'h4444_4444));
        chk("wr_valid_mask", 160'(valid_mask), 160'(5'b10001));

        write_enable = 1'b1; write_index = 3'd6; write_data = 32'h6666_6666;
        read_index0 = 3'd6;
        step();
        chk("oob_write_all_data", all_data, {32'h4444_4444, RV, RV, RV, 32'h1111_1111});
        chk("oob_write_valid_mask", 160'(valid_mask), 160'(5'b10001));
        chk("oob_read_idx6", 160'(read_data0), 160'(32'h0));

        clear = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            shift_enable = 1'b1; shift_data = 32'(i);
            step();
        end
        chk("shift5_all_data", all_data, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        chk("shift5_full", 160'(full), 160'(1'b1));
        shift_enable = 1'b1; shift_data = 32'd6;
        step();
        chk("shift6_all_data", all_data, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2});
        chk("shift6_full", 160'(full), 160'(1'b1));

        shift_enable = 1'b1; shift_data = 32'd7;
        write_enable = 1'b1; write_index = 3'd0; write_data = 32'd9;
        read_index0 = 3'd0;
        step();
        chk("shift_beats_write_all", all_data, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3});
        chk("shift_beats_write_e0", 160'(read_data0), 160'(32'd3));

        clear = 1'b1; shift_enable = 1'b1; shift_data = 32'd8;
        step();
        chk("clear_beats_shift_all", all_data, {5{RV}});
        chk("clear_beats_shift_mask", 160'(valid_mask), 160'(5'b00000));

        write_enable = 1'b1; write_index = 3'd3; write_data = 32'hAAAA_AAAA;
        step();
        write_enable = 1'b1; write_index = 3'd3; write_data = 32'hBBBB_BBBB;
        read_index0 = 3'd3;
        #1;
        chk("rdw_before_edge", 160'(read_data0), 160'(32'hAAAA_AAAA));
        step();
        chk("rdw_after_edge", 160'(read_data0), 160'(32'hBBBB_BBBB));

        reset = 1'b1; shift_enable = 1'b1; shift_data = 32'hCCCC_CCCC;
        write_enable = 1'b1; write_index = 3'd1; write_data = 32'hDDDD_DDDD;
        step();
        chk("midop_reset_all", all_data, {5{RV}});
        chk("midop_reset_mask", 160'(valid_mask), 160'(5'b00000));
        shift_enable = 1'b1; shift_data = 32'h1234_5678;
        step();
        chk("post_reset_shift_all", all_data, {32'h1234_5678, RV, RV, RV, RV});
        chk("post_reset_shift_mask", 160'(valid_mask), 160'(5'b10000));

        for (int i = 0; i < 8; i++) begin
            read_index0 = 3'(i);
            read_index1 = 3'(7 - i);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
